mcs4_clkgen: RTL

//  MCS-4 two-phase clock, SYNC and power-on-clear generator, derived from sysclk.

---
 rtl/mcs4_clkgen.sv | 118 +++++++++++
 1 files changed

// File: rtl/mcs4_clkgen.sv
// MCS-4 two-phase clock, SYNC and power-on-clear generator running off sysclk,
// with run/stop and single instruction-cycle step control.
module mcs4_clkgen #(
  parameter int unsigned PERIOD     = 64,
  parameter int unsigned CLK1_W     = 16,
  parameter int unsigned CLK2_START = 32,
  parameter int unsigned CLK2_W     = 16,
  parameter int unsigned POC_CYCLES = 8
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic       poc_req,
  output logic       clk1_pad,
  output logic       clk2_pad,
  output logic       sync_pad,
  output logic       poc_pad,
  output logic       running,
  output logic [2:0] subcycle,
  output logic       cycle_done
);

  localparam int unsigned PW = $clog2(PERIOD + 1);

  localparam logic [PW-1:0] P_LAST    = PW'(PERIOD - 1);
  localparam logic [PW-1:0] P_CLK1_W  = PW'(CLK1_W);
  localparam logic [PW-1:0] P_CLK2_S  = PW'(CLK2_START);
  localparam logic [PW-1:0] P_CLK2_E  = PW'(CLK2_START + CLK2_W);
  localparam logic [7:0]    POC_LOAD  = 8'(POC_CYCLES);

  localparam logic [1:0] S_STOPPED = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_STEP    = 2'd2;

  if (PERIOD < 2 || PERIOD > 256 || CLK1_W == 0 || CLK2_W == 0 ||
      CLK2_START < CLK1_W + 1 || CLK2_START + CLK2_W > PERIOD - 1 ||
      POC_CYCLES < 1 || POC_CYCLES > 255) begin : g_param_check
    $error("mcs4_clkgen: invalid clock parameters");
  end

  logic [1:0]    state, state_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [2:0]    cyc, cyc_n;
  logic [7:0]    poc_cnt, poc_n;
  logic          step_d;
  logic          rise, boundary, active_n;
  logic          clk1_n, clk2_n, sync_n;

  // Next-state, counters and the output decode of the post-edge values.
  always_comb begin
    state_n  = state;
    pcnt_n   = pcnt;
    cyc_n    = cyc;
    poc_n    = poc_cnt;
    rise     = step & ~step_d;
    boundary = (state != S_STOPPED) && (pcnt == P_LAST) && (cyc == 3'd7);

    case (state)
      S_STOPPED: begin
        if (run)       state_n = S_RUN;
        else if (rise) state_n = S_STEP;
      end
      S_RUN:   if (boundary && !run) state_n = S_STOPPED;
      S_STEP:  if (boundary)         state_n = S_STOPPED;
      default: state_n = S_STOPPED;
    endcase

    if (state == S_STOPPED) begin
      pcnt_n = '0;
      cyc_n  = 3'd0;
    end else if (pcnt == P_LAST) begin
      pcnt_n = '0;
      cyc_n  = cyc + 3'd1;
    end else begin
      pcnt_n = pcnt + PW'(1);
    end

    if (poc_req)                         poc_n = POC_LOAD;
    else if (boundary && poc_cnt != 8'd0) poc_n = poc_cnt - 8'd1;

    active_n = (state_n != S_STOPPED);
    clk1_n   = active_n && (pcnt_n < P_CLK1_W);
    clk2_n   = active_n && (pcnt_n >= P_CLK2_S) && (pcnt_n < P_CLK2_E);
    sync_n   = active_n && (cyc_n == 3'd7);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_STOPPED;
      pcnt       <= '0;
      cyc        <= 3'd0;
      step_d     <= 1'b0;
      poc_cnt    <= POC_LOAD;
      clk1_pad   <= 1'b0;
      clk2_pad   <= 1'b0;
      sync_pad   <= 1'b0;
      poc_pad    <= 1'b1;
      running    <= 1'b0;
      subcycle   <= 3'd0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_n;
      pcnt       <= pcnt_n;
      cyc        <= cyc_n;
      step_d     <= step;
      poc_cnt    <= poc_n;
      clk1_pad   <= clk1_n;
      clk2_pad   <= clk2_n;
      sync_pad   <= sync_n;
      poc_pad    <= (poc_n != 8'd0);
      running    <= active_n;
      subcycle   <= cyc_n;
      cycle_done <= boundary;
    end
  end

endmodule
